// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, legal prescale range
// and the majority-vote helper used by the receive oversampler.
package uart_pkg;

    localparam int DATA_W       = 8;
    localparam int PRESCALE_MIN = 8;
    localparam int PRESCALE_MAX = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Three-point oversampler: captures RX_IN around mid-bit and registers the
// majority value, which is valid from edge_cnt = P/2+2 until the next bit's vote.
module uart_rx_data_sampling
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic [5:0] edge_cnt,
    input  logic       enable,
    output logic       sampled_bit
);

    logic [5:0] mid;
    logic       s0_q;
    logic       s1_q;
    logic       bit_q;

    assign mid = {1'b0, Prescale[5:1]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
            bit_q <= 1'b1;
        end else if (enable) begin
            if (edge_cnt == mid - 6'd1) s0_q  <= RX_IN;
            if (edge_cnt == mid)        s1_q  <= RX_IN;
            if (edge_cnt == mid + 6'd1) bit_q <= majority3(s0_q, s1_q, RX_IN);
        end
    end

    assign sampled_bit = bit_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with oversampled majority voting;
// presents good bytes with a Data_Valid strobe and pulses parity/stop errors.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a low level (frame cycle 0)
//  START  | start bit; a high majority vote means a glitch, back to IDLE
//  DATA   | eight data bits, LSB first
//  PARITY | optional parity bit, mismatch latched into par_err
//  STOP   | stop bit; result pulse issued on the cycle after it ends
module uart_rx
    import uart_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [5:0]        Prescale,
    output logic [DATA_W-1:0] P_DATA,
    output logic              Data_Valid,
    output logic              Parity_Error,
    output logic              Stop_Error
);

    rx_state_e         state_q, state_d;
    logic [5:0]        edge_cnt_q, edge_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              par_err_q, par_err_d;
    logic              dv_q, dv_d;
    logic              perr_q, perr_d;
    logic              serr_q, serr_d;
    logic              sampled_bit;
    logic              bit_end;
    logic              stp_err;

    uart_rx_data_sampling u_sampling (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .edge_cnt    (edge_cnt_q),
        .enable      (state_q != S_IDLE),
        .sampled_bit (sampled_bit)
    );

    assign bit_end = (edge_cnt_q == Prescale - 6'd1);
    assign stp_err = ~sampled_bit;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_err_d  = par_err_q;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        edge_cnt_d = (state_q == S_IDLE || bit_end) ? 6'd0 : edge_cnt_q + 6'd1;

        unique case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    state_d    = S_START;
                    edge_cnt_d = 6'd1;
                    bit_cnt_d  = 3'd0;
                    par_err_d  = 1'b0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end
            end
            S_START: begin
                if (bit_end) state_d = sampled_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d[bit_cnt_q] = sampled_bit;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_err_d = (sampled_bit != (^shift_q ^ par_typ_q));
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Outcome is registered here so it appears on the first IDLE cycle.
                if (bit_end) begin
                    state_d = S_IDLE;
                    perr_d  = par_err_q;
                    serr_d  = stp_err;
                    if (!par_err_q && !stp_err) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_err_q  <= 1'b0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_err_q  <= par_err_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && state_q != S_IDLE)
            assert (Prescale >= 6'(PRESCALE_MIN) && Prescale <= 6'(PRESCALE_MAX) && !Prescale[0]);
    end

    assign P_DATA       = p_data_q;
    assign Data_Valid   = dv_q;
    assign Parity_Error = perr_q;
    assign Stop_Error   = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives per-cycle line waveforms and checks every output cycle
// against a frame-level stream decoder, plus table and hand-written corner cases.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    always #5 CLK = ~CLK;

    uart_rx dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Prescale     (Prescale),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error)
    );

    // pulse kind bits: 1 = Data_Valid, 2 = Parity_Error, 4 = Stop_Error
    typedef struct {
        int         cycle;
        int         kind;
        logic [7:0] data;
    } pulse_t;

    typedef struct {
        int         p;
        bit         pe;
        bit         pt;
        logic [7:0] d;
        bit         pflip;
        bit         stopb;
        int         glitch;
        int         exp_kind;
        int         exp_cycle;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic       wave[$];
    int         p_cur = 8;
    bit         pe_cur = 1'b0;
    bit         pt_cur = 1'b0;
    logic [7:0] model_pdata = 8'h00;
    pulse_t     obs[$];
    vec_t       vecs[9];

    function automatic logic line_at(int c);
        if (c < wave.size()) return wave[c];
        return 1'b1;
    endfunction

    function automatic logic vote(int c);
        logic a, b, d;
        a = line_at(c);
        b = line_at(c + 1);
        d = line_at(c + 2);
        return (a & b) | (a & d) | (b & d);
    endfunction

    task automatic check_int(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_bits(logic v, int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic add_frame(logic [7:0] d, bit pflip, bit stopb);
        add_bits(1'b0, p_cur);
        for (int i = 0; i < 8; i++) add_bits(d[i], p_cur);
        if (pe_cur) add_bits(^d ^ pt_cur ^ pflip, p_cur);
        add_bits(stopb, p_cur);
    endtask

    task automatic set_cfg(int p, bit pe, bit pt);
        p_cur    = p;
        pe_cur   = pe;
        pt_cur   = pt;
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        wave.delete();
    endtask

    // Decode the whole waveform frame by frame, then drive it and compare every cycle.
    task automatic run_stream(string name);
        pulse_t     exp_q[$];
        int         idx;
        int         n;
        int         e;
        int         h;
        bit         bad;
        logic [7:0] held;
        logic [2:0] ek, ak;
        idx  = 0;
        h    = p_cur / 2 - 1;
        bad  = 1'b0;
        held = model_pdata;
        obs.delete();
        while (idx < wave.size()) begin
            if (wave[idx] == 1'b0) begin
                int         s;
                int         k;
                logic [7:0] d;
                logic       pb, sb;
                s = idx;
                if (vote(s + h)) begin
                    idx = s + p_cur;
                end else begin
                    for (int i = 0; i < 8; i++) d[i] = vote(s + (1 + i) * p_cur + h);
                    pb = pe_cur ? vote(s + 9 * p_cur + h) : 1'b0;
                    sb = vote(s + (9 + int'(pe_cur)) * p_cur + h);
                    k = 0;
                    if (pe_cur && (pb != (^d ^ pt_cur))) k = k | 2;
                    if (!sb) k = k | 4;
                    if (k == 0) k = 1;
                    idx = s + (10 + int'(pe_cur)) * p_cur;
                    exp_q.push_back('{idx, k, d});
                end
            end else begin
                idx++;
            end
        end
        n = ((idx > wave.size()) ? idx : wave.size()) + 2;
        e = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge CLK);
            #1;
            ek = 3'd0;
            if (e < exp_q.size() && exp_q[e].cycle == c) begin
                ek = 3'(exp_q[e].kind);
                if (exp_q[e].kind == 1) held = exp_q[e].data;
                e++;
            end
            ak = {Stop_Error, Parity_Error, Data_Valid};
            if (ak != 3'd0) obs.push_back('{c, int'(ak), P_DATA});
            if (!bad && (ak !== ek || P_DATA !== held)) begin
                bad = 1'b1;
                $display("FAIL %s: cycle %0d got pulses=%0d P_DATA=%02h, expected pulses=%0d P_DATA=%02h",
                         name, c, ak, P_DATA, ek, held);
            end
            RX_IN = line_at(c);
        end
        tests++;
        if (bad) fails++;
        model_pdata = held;
    endtask

    initial begin
        logic [7:0] prev_good;
        vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1, 88};
        vecs[1] = '{32, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1, 320};
        vecs[2] = '{16, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, -1, 2, 176};
        vecs[3] = '{8,  1'b0, 1'b0, 8'h81, 1'b0, 1'b0, -1, 4, 80};
        vecs[4] = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 28, 1, 80};
        vecs[5] = '{12, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, -1, 6, 132};
        vecs[6] = '{32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, -1, 1, 352};
        vecs[7] = '{10, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, -1, 1, 110};
        vecs[8] = '{8,  1'b1, 1'b1, 8'h03, 1'b0, 1'b0, -1, 4, 88};

        repeat (3) @(posedge CLK);
        #1;
        check_int("reset_state", int'({P_DATA, Data_Valid, Parity_Error, Stop_Error}), 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        prev_good = 8'h00;
        for (int v = 0; v < 9; v++) begin
            set_cfg(vecs[v].p, vecs[v].pe, vecs[v].pt);
            add_bits(1'b1, 2);
            add_frame(vecs[v].d, vecs[v].pflip, vecs[v].stopb);
            if (vecs[v].glitch >= 0) wave[2 + vecs[v].glitch] = ~wave[2 + vecs[v].glitch];
            add_bits(1'b1, 4);
            run_stream($sformatf("vec%0d_stream", v));
            if (vecs[v].exp_kind == 1) prev_good = vecs[v].d;
            check_int($sformatf("vec%0d_npulses", v), obs.size(), 1);
            if (obs.size() >= 1) begin
                check_int($sformatf("vec%0d_kind", v), obs[0].kind, vecs[v].exp_kind);
                check_int($sformatf("vec%0d_cycle", v), obs[0].cycle - 2, vecs[v].exp_cycle);
                check_int($sformatf("vec%0d_pdata", v), int'(obs[0].data), int'(prev_good));
            end
        end

        // stop error followed immediately by a good frame
        set_cfg(8, 1'b0, 1'b0);
        add_bits(1'b1, 2);
        add_frame(8'hC3, 1'b0, 1'b0);
        add_frame(8'h55, 1'b0, 1'b1);
        add_bits(1'b1, 4);
        run_stream("b2b_stream");
        check_int("b2b_npulses", obs.size(), 2);
        if (obs.size() >= 2) begin
            check_int("b2b_first_kind", obs[0].kind, 4);
            check_int("b2b_first_cycle", obs[0].cycle - 2, 80);
            check_int("b2b_second_kind", obs[1].kind, 1);
            check_int("b2b_second_cycle", obs[1].cycle - 2, 160);
            check_int("b2b_second_data", int'(obs[1].data), 8'h55);
        end

        // two-cycle low glitch, then a real frame once the receiver is idle again
        set_cfg(8, 1'b0, 1'b0);
        add_bits(1'b1, 2);
        add_bits(1'b0, 2);
        add_bits(1'b1, 8);
        add_frame(8'h96, 1'b0, 1'b1);
        add_bits(1'b1, 4);
        run_stream("glitch_stream");
        check_int("glitch_npulses", obs.size(), 1);
        if (obs.size() >= 1) begin
            check_int("glitch_frame_cycle", obs[0].cycle, 92);
            check_int("glitch_frame_data", int'(obs[0].data), 8'h96);
        end

        // reset during data bit 4
        set_cfg(8, 1'b0, 1'b0);
        add_bits(1'b1, 2);
        add_frame(8'hA5, 1'b0, 1'b1);
        for (int c = 0; c < 2 + 5 * 8 + 3; c++) begin
            @(posedge CLK);
            #1;
            RX_IN = wave[c];
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check_int("midframe_reset_outputs", int'({P_DATA, Data_Valid, Parity_Error, Stop_Error}), 0);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        model_pdata = 8'h00;
        set_cfg(8, 1'b1, 1'b0);
        add_bits(1'b1, 2);
        add_frame(8'hFF, 1'b0, 1'b1);
        add_bits(1'b1, 4);
        run_stream("after_reset_stream");
        check_int("after_reset_npulses", obs.size(), 1);
        if (obs.size() >= 1) begin
            check_int("after_reset_cycle", obs[0].cycle - 2, 88);
            check_int("after_reset_data", int'(obs[0].data), 8'hFF);
        end

        for (int r = 0; r < 20; r++) begin
            set_cfg(8 + 2 * int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            add_bits(1'b1, 2);
            for (int f = 0; f < 3; f++) begin
                int start;
                int g;
                start = wave.size();
                add_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
                if ($urandom_range(0, 2) == 0) begin
                    g = start + int'($urandom_range(0, (10 + int'(pe_cur)) * p_cur - 1));
                    wave[g] = ~wave[g];
                end
                add_bits(1'b1, int'($urandom_range(0, 5)));
            end
            add_bits(1'b1, 4);
            run_stream($sformatf("random%0d_p%0d", r, p_cur));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
